huffman_bit_packer: RTL and testbench
=====================================

# huffman_bit_packer

Parametrised successor to the Huffman encoder's bit concatenation stage. It accepts one variable-length code per cycle over a valid/ready handshake and packs codes MSB-first into OUT_WIDTH-bit words. Completed words are buffered in an internal output FIFO. On the last code of a stream it emits a final, left-aligned partial word together with its valid-bit count. It sits between the Huffman code lookup and the bitstream writer.

## Interface
- DATA_WIDTH, 64, maximum code length and width of din
- LEN_WIDTH, 7, width of len; must hold the value DATA_WIDTH
- OUT_WIDTH, 128, packed word width; must be at least DATA_WIDTH
- FIFO_DEPTH, 4, output FIFO entries; must be at least 2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  code present
- in_ready  out  1  code accepted when in_valid && in_ready
- din  in  DATA_WIDTH  code, right-aligned; only din[len-1:0] is used
- len  in  LEN_WIDTH  code length, 0..DATA_WIDTH
- in_last  in  1  final code of the stream
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer pops the head when out_valid && out_ready
- dout  out  OUT_WIDTH  packed word; first code bit is at dout[OUT_WIDTH-1]
- out_len  out  $clog2(OUT_WIDTH)+1  number of valid bits in dout
- out_last  out  1  word ends the stream
- err  out  1  sticky flag: a len greater than DATA_WIDTH was seen
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- State: accumulator acc[OUT_WIDTH-1:0], bit count cnt in 0..OUT_WIDTH-1, and FSM {RUN, FLUSH}.
- in_ready is combinational: (state==RUN) && (level <= FIFO_DEPTH-2). This guarantees room for two pushes.
- On accept, with L = min(len, DATA_WIDTH), the code bits are appended immediately below the cnt bits already in acc.
- Case cnt+L < OUT_WIDTH: the bits are placed in acc and cnt increases by L. Nothing is pushed.
- Case cnt+L >= OUT_WIDTH: one word is pushed. It consists of acc's cnt bits followed by the top OUT_WIDTH-cnt bits of the code, with out_len=OUT_WIDTH.
  - The remaining r = cnt+L-OUT_WIDTH bits start the new acc, and cnt=r.
  - At most one full word is produced per accepted code.
- in_last accepted with cnt_new == 0: the pushed word (or none, if none is pushed) closes the stream.
  - If a full word is pushed, it carries out_last=1.
  - If no word is pushed (len=0 and cnt=0), a zero word is pushed with out_len=0 and out_last=1.
- in_last accepted with cnt_new > 0: any full word is pushed in that cycle without out_last. The FSM then enters FLUSH.
- In FLUSH, the partial word is pushed: acc left-aligned with padding below it, out_len=cnt, out_last=1. Then cnt clears and the FSM returns to RUN.
- len == 0 without in_last is accepted and has no effect.
- len > DATA_WIDTH is clamped to DATA_WIDTH and sets err. err stays at 1 until reset.
- The FIFO pop and push may occur in the same cycle; level is unchanged in that case.

## Timing
- Reset values: out_valid 0, dout 0, out_len 0, out_last 0, err 0, level 0, cnt 0, acc 0, state RUN.
- in_ready is 1 in the first cycle after rst deasserts.
- Latency: a word pushed at edge N has out_valid=1 after edge N and is visible at the FIFO head when the FIFO was empty.
- dout, out_len and out_last hold stable while out_valid && !out_ready.
- FLUSH lasts exactly one cycle, because the two free entries are guaranteed. in_ready is 0 during FLUSH.
- Sustained throughput is one code per cycle while out_ready=1.
- Asserting rst mid-stream clears the FIFO, acc and the FSM immediately. Partial data is discarded.

## Configuration
- HUFF_PACK_ONES_PAD_EN defined: bits below out_len in the final partial word are filled with 1s (JPEG-style fill).
- HUFF_PACK_ONES_PAD_EN undefined: those bits are 0.
- Full words are unaffected in both cases.

## Test plan
- Repeated codes, OUT_WIDTH=128: 30 codes of din=0x5F, len=7, in_last on the 30th, out_ready=1.
  - Word 0 is 18×7'b1011111 followed by 2'b10, with out_len=128 and out_last=0.
  - Word 1 is 5'b11111 followed by 11×7'b1011111, followed by 46 zeros, with out_len=82 and out_last=1.
- Exact boundary: 16 codes of din=0xA5, len=8, in_last on the 16th.
  - Exactly one word is produced: 0xA5 repeated 16 times, out_len=128, out_last=1. No FLUSH word follows.
- Flush-only last: code 3'b101 (len=3), then len=0 with in_last.
  - One word is produced: dout=0xA000…0, out_len=3, out_last=1.
  - With HUFF_PACK_ONES_PAD_EN defined, dout=0xBFFF…F.
- Backpressure: out_ready=0 while streaming 64-bit codes.
  - in_ready drops once level reaches FIFO_DEPTH-1.
  - After releasing out_ready, every word matches the reference model and none is lost.
- Clamp: len=70 with din=all-ones.
  - 64 bits are appended and err=1. err stays at 1 through later valid codes.
- Reset mid-stream: assert rst with level=2 and cnt=40.
  - All outputs return to their reset values.
  - A fresh 30×7-bit stream then reproduces the first scenario exactly.

Source files
------------

// File: rtl/huffman_bit_packer_if.sv
// huffman_bit_packer_if: code input, packed-word output and status signals of the Huffman bit packer.
interface huffman_bit_packer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 7,
    parameter int OUT_WIDTH  = 128,
    parameter int FIFO_DEPTH = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_WIDTH-1:0]         din;
    logic [LEN_WIDTH-1:0]          len;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [OUT_WIDTH-1:0]          dout;
    logic [$clog2(OUT_WIDTH):0]    out_len;
    logic                          out_last;
    logic                          err;
    logic [$clog2(FIFO_DEPTH):0]   level;
    modport master (
        output in_valid, din, len, in_last, out_ready,
        input  in_ready, out_valid, dout, out_len, out_last, err, level
    );
    modport slave (
        input  in_valid, din, len, in_last, out_ready,
        output in_ready, out_valid, dout, out_len, out_last, err, level
    );
endinterface

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: packs variable-length codes MSB-first into OUT_WIDTH-bit words behind an output FIFO.
// HUFF_PACK_ONES_PAD_EN: fill the unused tail of the final partial word with 1s instead of 0s.
module huffman_bit_packer #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 7,
    parameter int OUT_WIDTH  = 128,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    huffman_bit_packer_if.slave bus
);
    localparam int CW  = $clog2(OUT_WIDTH);
    localparam int OLW = CW + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LVW = AW + 1;
    localparam int SW  = 16;
    localparam int WW  = 2 * OUT_WIDTH;
    localparam logic [LEN_WIDTH-1:0] LMAX = LEN_WIDTH'(DATA_WIDTH);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state_q, state_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d, flush_word, push_word;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_new;
    logic                 err_q, err_d;
    logic [LVW-1:0]       level_q, level_d;
    logic [AW-1:0]        wr_q, rd_q;
    logic [OUT_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [OLW-1:0]       mem_l [FIFO_DEPTH];
    logic                 mem_last [FIFO_DEPTH];
    logic [LEN_WIDTH-1:0] l;
    logic [DATA_WIDTH-1:0] code;
    logic [SW-1:0]        sum;
    logic [WW-1:0]        wide;
    logic [OLW-1:0]       push_len;
    logic                 accept, full, push, pop, push_last, ready, flushing;
    // The code lands directly below the cnt bits held in acc; the upper half of
    // wide is the candidate full word, the lower half the left-aligned remainder.
    always_comb begin
        l        = (bus.len > LMAX) ? LMAX : bus.len;
        code     = bus.din & ((l == LMAX) ? {DATA_WIDTH{1'b1}} : ((DATA_WIDTH'(1) << l) - DATA_WIDTH'(1)));
        sum      = SW'(cnt_q) + SW'(l);
        wide     = {acc_q, {OUT_WIDTH{1'b0}}} | (WW'(code) << (SW'(WW) - sum));
        full     = sum >= SW'(OUT_WIDTH);
        cnt_new  = full ? CW'(sum - SW'(OUT_WIDTH)) : CW'(sum);
        accept   = bus.in_valid && ready;
`ifdef HUFF_PACK_ONES_PAD_EN
        flush_word = acc_q | ({OUT_WIDTH{1'b1}} >> cnt_q);
`else
        flush_word = acc_q;
`endif
        push      = flushing || (accept && (full || (bus.in_last && cnt_new == '0)));
        push_word = flushing ? flush_word : wide[WW-1:OUT_WIDTH];
        push_len  = flushing ? OLW'(cnt_q) : (full ? OLW'(OUT_WIDTH) : '0);
        push_last = flushing || (bus.in_last && cnt_new == '0);
        acc_d     = flushing ? '0 : (!accept ? acc_q : (full ? wide[OUT_WIDTH-1:0] : wide[WW-1:OUT_WIDTH]));
        cnt_d     = flushing ? '0 : (accept ? cnt_new : cnt_q);
        err_d     = err_q || (accept && bus.len > LMAX);
        pop       = bus.out_valid && bus.out_ready;
        level_d   = level_q + LVW'(push) - LVW'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == FLUSH) ? RUN : ((accept && bus.in_last && cnt_new != '0) ? FLUSH : RUN);
    end
    always_comb begin
        flushing = state_q == FLUSH;
        ready    = (state_q == RUN) && (level_q <= LVW'(FIFO_DEPTH - 2));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            level_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            level_q <= level_d;
            if (push) wr_q <= (wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + AW'(1);
            if (pop)  rd_q <= (rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + AW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wr_q]    <= push_word;
            mem_l[wr_q]    <= push_len;
            mem_last[wr_q] <= push_last;
        end
    end
    // Head fields read as zero while the FIFO is empty, giving clean reset values.
    always_comb begin
        bus.in_ready  = ready;
        bus.out_valid = level_q != '0;
        bus.dout      = bus.out_valid ? mem_d[rd_q] : '0;
        bus.out_len   = bus.out_valid ? mem_l[rd_q] : '0;
        bus.out_last  = bus.out_valid && mem_last[rd_q];
        bus.err       = err_q;
        bus.level     = level_q;
    end
endmodule

// File: tb/tb_huffman_bit_packer.sv
// tb_huffman_bit_packer: randomized scoreboard bench; a bit-queue model predicts every packed word.
module tb_huffman_bit_packer;
    localparam int W = 128;
    localparam int D = 4;
`ifdef HUFF_PACK_ONES_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    huffman_bit_packer_if bus ();
    huffman_bit_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_d[$];
    int           exp_l[$];
    bit           exp_last[$];
    bit           bq[$];
    bit           exp_err = 1'b0;
    bit           rand_or = 1'b0;
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask
    // Reference: the stream is a plain queue of bits; every 128 collected bits form a word.
    function automatic void model(input logic [63:0] d, input int l, input bit last);
        int L = (l > 64) ? 64 : l;
        logic [W-1:0] w;
        bit made = 1'b0;
        int n;
        if (l > 64) exp_err = 1'b1;
        for (int i = L - 1; i >= 0; i--) bq.push_back(d[i]);
        if (bq.size() >= W) begin
            for (int i = 0; i < W; i++) w[W-1-i] = bq.pop_front();
            made = 1'b1;
            exp_d.push_back(w); exp_l.push_back(W); exp_last.push_back(last && bq.size() == 0);
        end
        if (last && bq.size() == 0 && !made) begin
            exp_d.push_back('0); exp_l.push_back(0); exp_last.push_back(1'b1);
        end
        if (last && bq.size() > 0) begin
            n = bq.size();
            w = PAD ? {W{1'b1}} : '0;
            for (int i = 0; i < n; i++) w[W-1-i] = bq.pop_front();
            exp_d.push_back(w); exp_l.push_back(n); exp_last.push_back(1'b1);
        end
    endfunction
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_d.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_word: got %h want none", bus.dout);
            end else begin
                chk("word_data", bus.dout, exp_d.pop_front());
                chk("word_len", W'(bus.out_len), W'(exp_l.pop_front()));
                chk("word_last", W'(bus.out_last), W'(exp_last.pop_front()));
            end
        end
    end
    initial forever begin
        @(posedge clk); #1;
        if (rand_or) bus.out_ready = 1'($urandom_range(0, 1));
    end
    task automatic send(input logic [63:0] d, input int l, input bit last);
        int n = 0;
        bus.in_valid = 1'b1; bus.din = d; bus.len = 7'(l); bus.in_last = last;
        do begin @(negedge clk); n++; end while (!bus.in_ready && n < 300);
        if (!bus.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got in_ready 0 want 1");
        end else model(d, l, last);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while ((exp_d.size() != 0 || bus.out_valid) && n < 1000) begin @(negedge clk); n++; end
        chk("drain_left", W'(exp_d.size()), '0);
        @(posedge clk); #1;
    endtask
    task automatic stream7();
        for (int i = 0; i < 30; i++) send(64'h5F, 7, i == 29);
    endtask
    task automatic chk_reset_vals();
        chk("rst_out_valid", W'(bus.out_valid), '0);
        chk("rst_dout", bus.dout, '0);
        chk("rst_out_len", W'(bus.out_len), '0);
        chk("rst_out_last", W'(bus.out_last), '0);
        chk("rst_err", W'(bus.err), '0);
        chk("rst_level", W'(bus.level), '0);
    endtask
    initial begin
        bus.in_valid = 1'b0; bus.din = '0; bus.len = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        #2 chk_reset_vals();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk) chk("ready_after_rst", W'(bus.in_ready), W'(1));
        @(posedge clk); #1;
        stream7(); drain();
        for (int i = 0; i < 16; i++) send(64'hA5, 8, i == 15);
        drain();
        send(64'h5, 3, 1'b0); send(64'h0, 0, 1'b1); drain();
        send({64{1'b1}}, 70, 1'b0);
        chk("err_set", W'(bus.err), W'(1));
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, $urandom_range(0, 64), i == 3);
        chk("err_sticky", W'(bus.err), W'(exp_err));
        drain();
        bus.out_ready = 1'b0;
        fork
            for (int i = 0; i < 10; i++) send({$urandom, $urandom}, 64, i == 9);
            begin
                int n = 0;
                while (bus.level != 3'(D - 1) && n < 100) begin @(negedge clk); n++; end
                chk("bp_level", W'(bus.level), W'(D - 1));
                chk("bp_in_ready", W'(bus.in_ready), '0);
                repeat (5) @(negedge clk);
                chk("bp_level_hold", W'(bus.level), W'(D - 1));
                @(posedge clk); #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        rand_or = 1'b1;
        for (int s = 0; s < 6; s++) begin
            int n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send({$urandom, $urandom}, $urandom_range(0, 64), i == n - 1);
            end
        end
        rand_or = 1'b0;
        @(posedge clk); #2 bus.out_ready = 1'b1;
        drain();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 64, 1'b0);
        send({$urandom, $urandom}, 40, 1'b0);
        chk("mid_level", W'(bus.level), W'(2));
        rst_n = 1'b0;
        #1 chk_reset_vals();
        bq.delete(); exp_d.delete(); exp_l.delete(); exp_last.delete(); exp_err = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk) chk("ready_after_rst2", W'(bus.in_ready), W'(1));
        @(posedge clk); #1 bus.out_ready = 1'b1;
        stream7(); drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
